cpu_sequencer: RTL and testbench

Multi-cycle instruction sequencer for the 16-bit CPU. It steps each instruction through fetch, decode, execute, memory and writeback, and drives the datapath strobes (IR/PC load, memory request, register write, mux selects) from the 4-bit opcode. It handshakes with instruction/data memory, which may insert wait states, and times out on a hung memory. It sits between the control unit's opcode decode and the datapath registers.

---
 rtl/cpu_sequencer.sv | 165 ++++++++++++++++
 tb/tb_cpu_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle fetch/decode/exec/mem/writeback sequencer for the 16-bit CPU
module cpu_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [3:0]       opcode,
    input  logic             zero,
    input  logic             memAck,
    output logic             memReq,
    output logic             memWe,
    output logic             memAddrSel,
    output logic             irWrite,
    output logic             pcWrite,
    output logic [1:0]       pcSrc,
    output logic             regWrite,
    output logic [1:0]       wbSel,
    output logic [2:0]       state,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'b000,
        S_FETCH  = 3'b001,
        S_DECODE = 3'b010,
        S_EXEC   = 3'b011,
        S_MEM    = 3'b100,
        S_WB     = 3'b101,
        S_HALT   = 3'b110
    } state_t;

    localparam logic [3:0] OP_LDW = 4'hA;
    localparam logic [3:0] OP_STW = 4'hB;
    localparam logic [3:0] OP_BRZ = 4'hC;
    localparam logic [3:0] OP_JMP = 4'hD;
    localparam logic [3:0] OP_JAL = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // A wait cycle that finds the counter at LIMIT is the MEM_TIMEOUT-th unacked cycle.
    localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT - 1);

    state_t           state_q;
    state_t           state_d;
    state_t           boundary;
    logic [7:0]       wait_cnt;
    logic             timeout;
    logic             retire;
    logic             fault_q;
    logic [CNT_W-1:0] retired_q;

    // Next-state and datapath strobes; the instruction boundary target depends on run.
    always_comb begin
        state_d    = state_q;
        memReq     = 1'b0;
        memWe      = 1'b0;
        memAddrSel = 1'b0;
        irWrite    = 1'b0;
        pcWrite    = 1'b0;
        pcSrc      = 2'b00;
        regWrite   = 1'b0;
        wbSel      = 2'b00;
        timeout    = 1'b0;
        retire     = 1'b0;
        boundary   = run ? S_FETCH : S_IDLE;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                memReq = 1'b1;
                if (memAck) begin
                    irWrite = 1'b1;
                    pcWrite = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_cnt == LIMIT) begin
                    timeout = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_DECODE: begin
                state_d = (opcode == OP_HLT) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                case (opcode)
                    OP_LDW, OP_STW: state_d = S_MEM;
                    OP_BRZ: begin
                        pcWrite = zero;
                        pcSrc   = 2'b01;
                        retire  = 1'b1;
                        state_d = boundary;
                    end
                    OP_JMP: begin
                        pcWrite = 1'b1;
                        pcSrc   = 2'b10;
                        retire  = 1'b1;
                        state_d = boundary;
                    end
                    OP_JAL: begin
                        regWrite = 1'b1;
                        wbSel    = 2'b10;
                        pcWrite  = 1'b1;
                        pcSrc    = 2'b10;
                        retire   = 1'b1;
                        state_d  = boundary;
                    end
                    OP_HLT:  state_d = S_HALT;
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                memReq     = 1'b1;
                memAddrSel = 1'b1;
                memWe      = (opcode == OP_STW);
                if (memAck) begin
                    if (opcode == OP_STW) begin
                        retire  = 1'b1;
                        state_d = boundary;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_cnt == LIMIT) begin
                    timeout = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_WB: begin
                regWrite = 1'b1;
                wbSel    = (opcode == OP_LDW) ? 2'b01 : 2'b00;
                retire   = 1'b1;
                state_d  = boundary;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // State, wait counter (counts only while stalling in the same access), sticky fault, retire count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wait_cnt  <= 8'd0;
            fault_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q  <= state_d;
            fault_q  <= fault_q | timeout;
            if (memReq && !memAck && (state_d == state_q)) begin
                wait_cnt <= wait_cnt + 8'd1;
            end else begin
                wait_cnt <= 8'd0;
            end
            if (retire) retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign state   = state_q;
    assign halted  = (state_q == S_HALT);
    assign fault   = fault_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - scoreboard bench for cpu_sequencer with directed per-cycle vectors
module tb_cpu_sequencer;

    localparam logic [2:0] IDLE = 3'b000, FETCH = 3'b001, DECODE = 3'b010, EXEC = 3'b011,
                           MEM = 3'b100, WB = 3'b101, HALT = 3'b110;
    localparam logic [3:0] ADD = 4'h0, LDW = 4'hA, STW = 4'hB, BRZ = 4'hC,
                           JMP = 4'hD, JAL = 4'hE, HLT = 4'hF;

    typedef struct packed {
        logic [2:0]  st;
        logic        req;
        logic        we;
        logic        asel;
        logic        irw;
        logic        pcw;
        logic [1:0]  psrc;
        logic        rw;
        logic [1:0]  wsel;
        logic        hlt;
        logic        flt;
        logic [15:0] ret;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [3:0]  opcode;
    logic        zero;
    logic        mem_ack;
    logic        mem_req;
    logic        mem_we;
    logic        mem_addr_sel;
    logic        ir_write;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic [2:0]  state;
    logic        halted;
    logic        fault;
    logic [15:0] retired;

    exp_t sb[$];
    int   tags[$];
    int   vec_id   = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    cpu_sequencer #(.MEM_TIMEOUT(15), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .zero(zero), .memAck(mem_ack),
        .memReq(mem_req), .memWe(mem_we), .memAddrSel(mem_addr_sel), .irWrite(ir_write),
        .pcWrite(pc_write), .pcSrc(pc_src), .regWrite(reg_write), .wbSel(wb_sel),
        .state(state), .halted(halted), .fault(fault), .retired(retired)
    );

    always #5 clk = ~clk;

    function automatic exp_t ev(input logic [2:0] st, input logic req, input logic we,
                                input logic asel, input logic irw, input logic pcw,
                                input logic [1:0] psrc, input logic rw, input logic [1:0] wsel,
                                input logic hlt, input logic flt, input logic [15:0] ret);
        exp_t x;
        x = {st, req, we, asel, irw, pcw, psrc, rw, wsel, hlt, flt, ret};
        return x;
    endfunction

    // Drive one cycle's inputs just after the edge and queue what the outputs must be in that cycle.
    task automatic step(input logic rs, input logic r, input logic [3:0] op, input logic z,
                        input logic ack, input exp_t ex);
        @(posedge clk);
        #1;
        rst = rs; run = r; opcode = op; zero = z; mem_ack = ack;
        vec_id++;
        sb.push_back(ex);
        tags.push_back(vec_id);
    endtask

    task automatic idle_c(input logic rs, input logic r, input logic ack, input logic [15:0] ret);
        step(rs, r, ADD, 1'b0, ack, ev(IDLE, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, ret));
    endtask

    task automatic fetch_ack(input logic [3:0] op, input logic [15:0] ret);
        step(1'b0, 1'b1, op, 1'b0, 1'b1, ev(FETCH, 1, 0, 0, 1, 1, 2'b00, 0, 2'b00, 0, 0, ret));
    endtask

    task automatic fetch_wait(input logic [3:0] op, input logic [15:0] ret);
        step(1'b0, 1'b1, op, 1'b0, 1'b0, ev(FETCH, 1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, ret));
    endtask

    task automatic dec(input logic [3:0] op, input logic r, input logic ack, input logic [15:0] ret);
        step(1'b0, r, op, 1'b0, ack, ev(DECODE, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, ret));
    endtask

    task automatic exec_quiet(input logic [3:0] op, input logic ack, input logic [15:0] ret);
        step(1'b0, 1'b1, op, 1'b0, ack, ev(EXEC, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, ret));
    endtask

    task automatic exec_jmp(input logic [15:0] ret);
        step(1'b0, 1'b1, JMP, 1'b0, 1'b0, ev(EXEC, 0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 0, 0, ret));
    endtask

    // Monitor: the sequencer presents outputs every cycle, so each queued expectation is checked mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t ex;
            exp_t act;
            int   tag;
            ex  = sb.pop_front();
            tag = tags.pop_front();
            act = {state, mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
                   reg_write, wb_sel, halted, fault, retired};
            n_checks++;
            if (act === ex) begin
                n_pass++;
            end else begin
                $display("FAIL vec%0d: got st=%b req/we/asel/irw/pcw=%b%b%b%b%b psrc=%b rw=%b wsel=%b hlt=%b flt=%b ret=%0d; required st=%b req/we/asel/irw/pcw=%b%b%b%b%b psrc=%b rw=%b wsel=%b hlt=%b flt=%b ret=%0d",
                         tag, act.st, act.req, act.we, act.asel, act.irw, act.pcw, act.psrc,
                         act.rw, act.wsel, act.hlt, act.flt, act.ret,
                         ex.st, ex.req, ex.we, ex.asel, ex.irw, ex.pcw, ex.psrc,
                         ex.rw, ex.wsel, ex.hlt, ex.flt, ex.ret);
            end
        end
    end

    initial begin
        rst = 1'b1; run = 1'b0; opcode = ADD; zero = 1'b0; mem_ack = 1'b0;

        // Reset state, then start
        idle_c(1'b1, 1'b0, 1'b0, 16'd0);
        idle_c(1'b0, 1'b1, 1'b0, 16'd0);

        // ADD, zero-wait: FETCH, DECODE, EXEC, WB
        fetch_ack(ADD, 16'd0);
        dec(ADD, 1'b1, 1'b0, 16'd0);
        exec_quiet(ADD, 1'b0, 16'd0);
        step(0, 1, ADD, 0, 0, ev(WB, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 0, 0, 16'd0));

        // LDW with 3 wait cycles in MEM, 8 cycles total
        fetch_ack(LDW, 16'd1);
        dec(LDW, 1'b1, 1'b0, 16'd1);
        exec_quiet(LDW, 1'b0, 16'd1);
        repeat (3) step(0, 1, LDW, 0, 0, ev(MEM, 1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 0, 0, 16'd1));
        step(0, 1, LDW, 0, 1, ev(MEM, 1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 0, 0, 16'd1));
        step(0, 1, LDW, 0, 0, ev(WB, 0, 0, 0, 0, 0, 2'b00, 1, 2'b01, 0, 0, 16'd1));

        // STW, stray acks in DECODE/EXEC are ignored
        fetch_ack(STW, 16'd2);
        dec(STW, 1'b1, 1'b1, 16'd2);
        exec_quiet(STW, 1'b1, 16'd2);
        step(0, 1, STW, 0, 1, ev(MEM, 1, 1, 1, 0, 0, 2'b00, 0, 2'b00, 0, 0, 16'd2));

        // BRZ not taken, then taken
        fetch_ack(BRZ, 16'd3);
        dec(BRZ, 1'b1, 1'b0, 16'd3);
        step(0, 1, BRZ, 0, 0, ev(EXEC, 0, 0, 0, 0, 0, 2'b01, 0, 2'b00, 0, 0, 16'd3));
        fetch_ack(BRZ, 16'd4);
        dec(BRZ, 1'b1, 1'b0, 16'd4);
        step(0, 1, BRZ, 1, 0, ev(EXEC, 0, 0, 0, 0, 1, 2'b01, 0, 2'b00, 0, 0, 16'd4));

        // JMP and JAL
        fetch_ack(JMP, 16'd5);
        dec(JMP, 1'b1, 1'b0, 16'd5);
        exec_jmp(16'd5);
        fetch_ack(JAL, 16'd6);
        dec(JAL, 1'b1, 1'b0, 16'd6);
        step(0, 1, JAL, 0, 0, ev(EXEC, 0, 0, 0, 0, 1, 2'b10, 1, 2'b10, 0, 0, 16'd6));

        // JAL with run dropped in DECODE: completes, then IDLE
        fetch_ack(JAL, 16'd7);
        dec(JAL, 1'b0, 1'b0, 16'd7);
        step(0, 0, JAL, 0, 0, ev(EXEC, 0, 0, 0, 0, 1, 2'b10, 1, 2'b10, 0, 0, 16'd7));
        idle_c(1'b0, 1'b0, 1'b1, 16'd8);
        idle_c(1'b0, 1'b1, 1'b0, 16'd8);

        // HALT opcode: no fault, sticky until reset
        fetch_ack(HLT, 16'd8);
        dec(HLT, 1'b1, 1'b0, 16'd8);
        step(0, 1, HLT, 0, 1, ev(HALT, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 0, 16'd8));
        step(0, 1, HLT, 0, 0, ev(HALT, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 0, 16'd8));
        step(1, 1, HLT, 0, 0, ev(HALT, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 0, 16'd8));
        idle_c(1'b0, 1'b1, 1'b0, 16'd0);

        // JMP, then ack on exactly the 15th FETCH cycle: no fault
        fetch_ack(JMP, 16'd0);
        dec(JMP, 1'b1, 1'b0, 16'd0);
        exec_jmp(16'd0);
        repeat (14) fetch_wait(JMP, 16'd1);
        fetch_ack(JMP, 16'd1);
        dec(JMP, 1'b1, 1'b0, 16'd1);
        exec_jmp(16'd1);

        // Hung FETCH: 15 unacked cycles then HALT with fault
        repeat (15) fetch_wait(JMP, 16'd2);
        step(0, 1, JMP, 0, 1, ev(HALT, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 1, 16'd2));
        step(1, 1, JMP, 0, 0, ev(HALT, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 1, 16'd2));
        idle_c(1'b0, 1'b1, 1'b0, 16'd0);

        // Reset in the middle of a stalled STW access
        fetch_ack(JMP, 16'd0);
        dec(JMP, 1'b1, 1'b0, 16'd0);
        exec_jmp(16'd0);
        fetch_ack(STW, 16'd1);
        dec(STW, 1'b1, 1'b0, 16'd1);
        exec_quiet(STW, 1'b0, 16'd1);
        step(0, 1, STW, 0, 0, ev(MEM, 1, 1, 1, 0, 0, 2'b00, 0, 2'b00, 0, 0, 16'd1));
        step(1, 1, STW, 0, 1, ev(MEM, 1, 1, 1, 0, 0, 2'b00, 0, 2'b00, 0, 0, 16'd1));
        idle_c(1'b0, 1'b0, 1'b0, 16'd0);
        idle_c(1'b0, 1'b0, 1'b0, 16'd0);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d entries left, required 0", sb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
